inst_envelope_ctrl: RTL and testbench

- Per-instrument intensity envelope controller that drives the inst_intensity[] bus of the dry visualiser.
- Accepts drum trigger events (instrument index, velocity) over a valid/ready handshake.
- Runs one serial decay pass per video frame, then commits all envelopes atomically, so the display sees values that stay constant for the whole frame.
- Sits between the trigger/sample-playback logic and the video path.

---
 rtl/dry_gen_pkg.sv | 21 ++
 rtl/inst_envelope_ctrl_if.sv | 33 +++
 rtl/env_decay_step.sv | 31 +++
 rtl/inst_envelope_ctrl.sv | 160 ++++++++++++++++
 tb/tb_inst_envelope_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dry_gen_pkg.sv
// Shared types and helpers for the dry visualiser envelope logic.
//   intensity_t  : 8-bit unsigned envelope value
//   env_state_t  : envelope controller FSM states
//   idx_width()  : index width for n instruments, never below 1 bit
package dry_gen_pkg;

    localparam int DEF_INSTRUMENT_COUNT = 3;

    typedef logic [7:0] intensity_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECAY  = 2'd1,
        COMMIT = 2'd2
    } env_state_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/inst_envelope_ctrl_if.sv
// Trigger channel into the envelope controller.
//   trig_valid    : master -> slave, request
//   trig_ready    : slave -> master, transfer happens when valid && ready
//   trig_idx      : master -> slave, instrument index
//   trig_velocity : master -> slave, trigger strength 0..255
// Handshake: a transfer occurs on every rising clock edge where trig_valid
// and trig_ready are both high. Once trig_valid is raised the master holds
// trig_valid, trig_idx and trig_velocity stable until that edge. trig_ready
// may be high with no request pending and carries no other meaning.
interface inst_envelope_ctrl_if #(
    parameter int IDX_W = 2
) ();

    logic             trig_valid;
    logic             trig_ready;
    logic [IDX_W-1:0] trig_idx;
    logic [7:0]       trig_velocity;

    modport master (
        output trig_valid,
        output trig_idx,
        output trig_velocity,
        input  trig_ready
    );

    modport slave (
        input  trig_valid,
        input  trig_idx,
        input  trig_velocity,
        output trig_ready
    );

endinterface

// File: rtl/env_decay_step.sv
// One decay step for a single envelope (purely combinational).
//   value_i : current envelope value
//   fresh_i : instrument was triggered since the last commit -> hold value
//   next_o  : value - max(value >> DECAY_SHIFT, 1), saturating at 0
module env_decay_step
    import dry_gen_pkg::*;
#(
    parameter int DECAY_SHIFT = 3
) (
    input  intensity_t value_i,
    input  logic       fresh_i,
    output intensity_t next_o
);

    intensity_t step;

    always_comb begin
        step = value_i >> DECAY_SHIFT;
        // Small values would otherwise never reach zero.
        if (step == '0) begin
            step = 8'd1;
        end
        // step <= value_i whenever value_i >= 1, so no underflow is possible.
        if (fresh_i || (value_i == '0)) begin
            next_o = value_i;
        end else begin
            next_o = value_i - step;
        end
    end

endmodule

// File: rtl/inst_envelope_ctrl.sv
// Per-instrument intensity envelope controller for the dry visualiser.
// Triggers raise an instrument's working envelope (unsigned max with the
// velocity). Each new_frame starts one serial decay pass (one instrument
// per cycle) followed by a COMMIT cycle that copies every working value to
// inst_intensity at once, so the video path sees a frame-stable bus.
//   clk, rst_n      : clock, asynchronous active-low reset
//   new_frame       : one-cycle frame tick
//   trig            : trigger channel (slave side), ready only in IDLE
//   inst_intensity  : committed envelope per instrument
//   commit          : one-cycle pulse with the first cycle of new values
//   frame_overrun   : one-cycle pulse after a new_frame dropped while busy
//   busy            : FSM not in IDLE
//   dbg_state       : current FSM state
module inst_envelope_ctrl
    import dry_gen_pkg::*;
#(
    parameter int INSTRUMENT_COUNT = DEF_INSTRUMENT_COUNT,
    parameter int DECAY_SHIFT      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  new_frame,
    inst_envelope_ctrl_if.slave   trig,
    output intensity_t            inst_intensity [INSTRUMENT_COUNT],
    output logic                  commit,
    output logic                  frame_overrun,
    output logic                  busy,
    output env_state_t            dbg_state
);

    localparam int IDX_W = idx_width(INSTRUMENT_COUNT);
    localparam int PTR_W = idx_width(INSTRUMENT_COUNT);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(INSTRUMENT_COUNT - 1);

    env_state_t                  state_q, state_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    intensity_t                  work_q [INSTRUMENT_COUNT];
    intensity_t                  work_d [INSTRUMENT_COUNT];
    logic [INSTRUMENT_COUNT-1:0] fresh_q, fresh_d;
    intensity_t                  intensity_q [INSTRUMENT_COUNT];
    intensity_t                  intensity_d [INSTRUMENT_COUNT];
    logic                        commit_q, commit_d;
    logic                        overrun_q, overrun_d;

    logic       trig_accept;
    intensity_t cur_value;
    logic       cur_fresh;
    intensity_t cur_next;

    assign trig.trig_ready = (state_q == IDLE);
    assign trig_accept     = trig.trig_valid && (state_q == IDLE);

    // Select the instrument under the decay pointer for the shared step unit.
    always_comb begin
        cur_value = '0;
        cur_fresh = 1'b0;
        for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
            if (ptr_q == PTR_W'(i)) begin
                cur_value = work_q[i];
                cur_fresh = fresh_q[i];
            end
        end
    end

    env_decay_step #(
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_decay_step (
        .value_i (cur_value),
        .fresh_i (cur_fresh),
        .next_o  (cur_next)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        work_d      = work_q;
        fresh_d     = fresh_q;
        intensity_d = intensity_q;
        commit_d    = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Trigger lands before a same-cycle frame tick, so the pass
                // that follows sees the merged value with fresh set.
                if (trig_accept) begin
                    for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
                        if (trig.trig_idx == IDX_W'(i)) begin
                            fresh_d[i] = 1'b1;
                            if (trig.trig_velocity > work_q[i]) begin
                                work_d[i] = trig.trig_velocity;
                            end
                        end
                    end
                end
                if (new_frame) begin
                    state_d = DECAY;
                    ptr_d   = '0;
                end
            end

            DECAY: begin
                for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
                    if (ptr_q == PTR_W'(i)) begin
                        work_d[i] = cur_next;
                    end
                end
                if (ptr_q == LAST_PTR) begin
                    state_d = COMMIT;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
                overrun_d = new_frame;
            end

            COMMIT: begin
                intensity_d = work_q;
                fresh_d     = '0;
                commit_d    = 1'b1;
                state_d     = IDLE;
                overrun_d   = new_frame;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            fresh_q   <= '0;
            commit_q  <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
                work_q[i]      <= '0;
                intensity_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            fresh_q   <= fresh_d;
            commit_q  <= commit_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
                work_q[i]      <= work_d[i];
                intensity_q[i] <= intensity_d[i];
            end
        end
    end

    assign inst_intensity = intensity_q;
    assign commit         = commit_q;
    assign frame_overrun  = overrun_q;
    assign busy           = (state_q != IDLE);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_inst_envelope_ctrl.sv
// Directed bench for inst_envelope_ctrl (3 instruments, DECAY_SHIFT = 3).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_inst_envelope_ctrl;
    import dry_gen_pkg::*;

    localparam int N = 3;

    logic       clk;
    logic       rst_n;
    logic       new_frame;
    logic [7:0] inst [N];
    logic       commit;
    logic       frame_overrun;
    logic       busy;
    env_state_t dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    inst_envelope_ctrl_if #(.IDX_W(2)) trig_if ();

    inst_envelope_ctrl #(
        .INSTRUMENT_COUNT (N),
        .DECAY_SHIFT      (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .new_frame      (new_frame),
        .trig           (trig_if),
        .inst_intensity (inst),
        .commit         (commit),
        .frame_overrun  (frame_overrun),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input string tag, input int e0, input int e1, input int e2);
        check_eq({tag, "_inst0"}, 32'(inst[0]), 32'(e0));
        check_eq({tag, "_inst1"}, 32'(inst[1]), 32'(e1));
        check_eq({tag, "_inst2"}, 32'(inst[2]), 32'(e2));
    endtask

    task automatic do_reset();
        rst_n                 = 1'b0;
        new_frame             = 1'b0;
        trig_if.trig_valid    = 1'b0;
        trig_if.trig_idx      = '0;
        trig_if.trig_velocity = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Driver: hold the request until accepted (bounded wait).
    task automatic send_trig(input logic [1:0] idx, input logic [7:0] vel);
        int n;
        n = 0;
        trig_if.trig_valid    = 1'b1;
        trig_if.trig_idx      = idx;
        trig_if.trig_velocity = vel;
        while (!trig_if.trig_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("trig_ready_wait", 32'(trig_if.trig_ready), 32'd1);
        @(negedge clk);
        trig_if.trig_valid = 1'b0;
    endtask

    // Pulse new_frame (optionally with a same-cycle trigger) and stop in the
    // cycle where commit is high; commit is expected 4 cycles after the tick.
    task automatic run_frame(input string tag, input logic with_trig,
                             input logic [1:0] idx, input logic [7:0] vel);
        int n;
        n = 0;
        new_frame = 1'b1;
        if (with_trig) begin
            trig_if.trig_valid    = 1'b1;
            trig_if.trig_idx      = idx;
            trig_if.trig_velocity = vel;
        end
        @(negedge clk);
        new_frame          = 1'b0;
        trig_if.trig_valid = 1'b0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (commit) break;
        end
        check_eq({tag, "_commit_latency"}, 32'(n), 32'd4);
    endtask

    initial begin
        int commits;
        int busy_seen;

        // Reset state
        do_reset();
        check_inst("reset", 0, 0, 0);
        check_eq("reset_commit", 32'(commit), 32'd0);
        check_eq("reset_overrun", 32'(frame_overrun), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_ready", 32'(trig_if.trig_ready), 32'd1);
        check_eq("reset_state", 32'(dbg_state), 32'(IDLE));

        // Decay curve from 200
        send_trig(2'd1, 8'd200);
        check_inst("pre_frame", 0, 0, 0);
        run_frame("curve_f1", 1'b0, 2'd0, 8'd0);
        check_inst("curve_f1", 0, 200, 0);
        check_eq("curve_overrun_quiet", 32'(frame_overrun), 32'd0);
        @(negedge clk);
        check_eq("commit_one_cycle", 32'(commit), 32'd0);
        check_inst("curve_hold", 0, 200, 0);
        run_frame("curve_f2", 1'b0, 2'd0, 8'd0);
        check_inst("curve_f2", 0, 175, 0);
        run_frame("curve_f3", 1'b0, 2'd0, 8'd0);
        check_inst("curve_f3", 0, 154, 0);
        run_frame("curve_f4", 1'b0, 2'd0, 8'd0);
        check_inst("curve_f4", 0, 135, 0);

        // Small-value tail: 5,4,3,2,1,0,0
        do_reset();
        send_trig(2'd0, 8'd5);
        for (int k = 0; k < 7; k++) begin
            run_frame("tail", 1'b0, 2'd0, 8'd0);
            check_eq("tail_inst0", 32'(inst[0]), (k < 5) ? 32'(5 - k) : 32'd0);
        end

        // Max merge, no decay after re-trigger, out-of-range index, velocity 0
        do_reset();
        send_trig(2'd2, 8'd100);
        send_trig(2'd2, 8'd50);
        run_frame("merge_f1", 1'b0, 2'd0, 8'd0);
        check_inst("merge_f1", 0, 0, 100);
        run_frame("merge_f2", 1'b0, 2'd0, 8'd0);
        check_inst("merge_f2", 0, 0, 88);
        send_trig(2'd2, 8'd255);
        run_frame("merge_f3", 1'b0, 2'd0, 8'd0);
        check_inst("merge_f3", 0, 0, 255);
        check_eq("idx3_ready", 32'(trig_if.trig_ready), 32'd1);
        send_trig(2'd3, 8'd255);
        check_inst("idx3_no_change", 0, 0, 255);
        run_frame("idx3_f", 1'b0, 2'd0, 8'd0);
        check_inst("idx3_f", 0, 0, 224);
        send_trig(2'd2, 8'd0);
        run_frame("vel0_f", 1'b0, 2'd0, 8'd0);
        check_inst("vel0_f", 0, 0, 224);

        // Trigger and new_frame in the same IDLE cycle
        do_reset();
        run_frame("same_f1", 1'b1, 2'd1, 8'd40);
        check_inst("same_f1", 0, 40, 0);
        run_frame("same_f2", 1'b0, 2'd0, 8'd0);
        check_inst("same_f2", 0, 35, 0);
        run_frame("same_f3", 1'b1, 2'd1, 8'd10);
        check_inst("same_f3", 0, 35, 0);

        // Busy handshake: request held from t+1 is accepted at t+5
        do_reset();
        new_frame = 1'b1;
        @(negedge clk);
        new_frame             = 1'b0;
        trig_if.trig_valid    = 1'b1;
        trig_if.trig_idx      = 2'd0;
        trig_if.trig_velocity = 8'd77;
        check_eq("busy_state_decay", 32'(dbg_state), 32'(DECAY));
        for (int k = 1; k <= 4; k++) begin
            check_eq("busy_ready_low", 32'(trig_if.trig_ready), 32'd0);
            check_eq("busy_high", 32'(busy), 32'd1);
            @(negedge clk);
        end
        check_eq("busy_ready_t5", 32'(trig_if.trig_ready), 32'd1);
        check_eq("busy_commit_t5", 32'(commit), 32'd1);
        check_eq("busy_inst0_t5", 32'(inst[0]), 32'd0);
        @(negedge clk);
        trig_if.trig_valid = 1'b0;
        check_eq("busy_inst0_after_accept", 32'(inst[0]), 32'd0);
        run_frame("busy_f", 1'b0, 2'd0, 8'd0);
        check_inst("busy_f", 77, 0, 0);

        // Overrun: second tick at t+2 is dropped
        do_reset();
        send_trig(2'd2, 8'd64);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        @(negedge clk);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        check_eq("ovr_pulse_t3", 32'(frame_overrun), 32'd1);
        check_eq("ovr_commit_t3", 32'(commit), 32'd0);
        @(negedge clk);
        check_eq("ovr_pulse_t4", 32'(frame_overrun), 32'd0);
        check_eq("ovr_commit_t4", 32'(commit), 32'd0);
        @(negedge clk);
        check_eq("ovr_commit_t5", 32'(commit), 32'd1);
        check_inst("ovr_t5", 0, 0, 64);
        commits   = 0;
        busy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (commit) commits++;
            if (busy) busy_seen++;
        end
        check_eq("ovr_no_extra_commit", 32'(commits), 32'd0);
        check_eq("ovr_no_extra_pass", 32'(busy_seen), 32'd0);
        run_frame("ovr_next", 1'b0, 2'd0, 8'd0);
        check_inst("ovr_next", 0, 0, 56);

        // Reset in the middle of a pass
        do_reset();
        send_trig(2'd0, 8'd90);
        run_frame("mid_f1", 1'b0, 2'd0, 8'd0);
        check_inst("mid_f1", 90, 0, 0);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        check_eq("mid_in_decay", 32'(dbg_state), 32'(DECAY));
        rst_n = 1'b0;
        #1;
        check_inst("mid_async", 0, 0, 0);
        check_eq("mid_async_busy", 32'(busy), 32'd0);
        check_eq("mid_async_commit", 32'(commit), 32'd0);
        commits = 0;
        repeat (4) begin
            @(negedge clk);
            if (commit) commits++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (commit) commits++;
        end
        check_eq("mid_no_commit", 32'(commits), 32'd0);
        check_inst("mid_after", 0, 0, 0);
        check_eq("mid_ready", 32'(trig_if.trig_ready), 32'd1);
        // Work registers were cleared too: a plain frame commits zeros.
        run_frame("mid_f2", 1'b0, 2'd0, 8'd0);
        check_inst("mid_f2", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
